// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares a single memory port (cbus) between the fetch stage's read-only
//   instruction bus (ibus) and the MEM stage's data bus (dbus). Only one
//   transaction is outstanding at a time. dbus wins ties, but after
//   STARVE_LIMIT consecutive dbus grants while ibus was waiting, ibus is
//   forced through.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ireq_valid/ireq_addr     fetch read request
//   iresp_addr_ok            ibus request accepted (combinational, IDLE only)
//   iresp_data_ok/_data      ibus read data returned (same cycle as cresp_ready)
//   dreq_*                   data request (write, addr, size, strobe, wdata)
//   dresp_addr_ok            dbus request accepted (combinational, IDLE only)
//   dresp_data_ok/_data      dbus transaction done / load data
//   creq_*                   registered memory request, held until cresp_ready
//   cresp_ready/cresp_data   single-beat memory response
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_addr_ok,
  output logic                iresp_data_ok,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic                dreq_write,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_wdata,
  output logic                dresp_addr_ok,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic                creq_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_wdata,
  input  logic                cresp_ready,
  input  logic [DATA_W-1:0]   cresp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    starve_cnt_reg, starve_cnt_next;
  logic                creq_valid_reg, creq_valid_next;
  logic                creq_write_reg, creq_write_next;
  logic [ADDR_W-1:0]   creq_addr_reg, creq_addr_next;
  logic [2:0]          creq_size_reg, creq_size_next;
  logic [STRB_W-1:0]   creq_strobe_reg, creq_strobe_next;
  logic [DATA_W-1:0]   creq_wdata_reg, creq_wdata_next;
  logic                grant_i, grant_d;
  logic [STRB_W-1:0]   dstrobe_masked;

  // Loads never drive byte enables onto the memory bus.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign dstrobe_masked[gi] = dreq_strobe[gi] & dreq_write;
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    starve_cnt_next  = starve_cnt_reg;
    creq_valid_next  = creq_valid_reg;
    creq_write_next  = creq_write_reg;
    creq_addr_next   = creq_addr_reg;
    creq_size_next   = creq_size_reg;
    creq_strobe_next = creq_strobe_reg;
    creq_wdata_next  = creq_wdata_reg;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    iresp_data_ok    = 1'b0;
    dresp_data_ok    = 1'b0;

    case (state_reg)
      IDLE: begin
        // cresp_ready is ignored here: nothing is outstanding.
        if (ireq_valid && (!dreq_valid || starve_cnt_reg == LIMIT)) begin
          grant_i = 1'b1;
        end else if (dreq_valid) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          state_next       = IBUSY;
          creq_valid_next  = 1'b1;
          creq_write_next  = 1'b0;
          creq_addr_next   = ireq_addr;
          creq_size_next   = 3'd3;
          creq_strobe_next = '0;
          creq_wdata_next  = '0;
          starve_cnt_next  = '0;
        end else if (grant_d) begin
          state_next       = DBUSY;
          creq_valid_next  = 1'b1;
          creq_write_next  = dreq_write;
          creq_addr_next   = dreq_addr;
          creq_size_next   = dreq_size;
          creq_strobe_next = dstrobe_masked;
          creq_wdata_next  = dreq_wdata;
          if (ireq_valid && starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
          end
        end

        // ibus not waiting means nobody is being starved.
        if (!ireq_valid) begin
          starve_cnt_next = '0;
        end
      end
      IBUSY: begin
        if (cresp_ready) begin
          iresp_data_ok   = 1'b1;
          creq_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      DBUSY: begin
        if (cresp_ready) begin
          dresp_data_ok   = 1'b1;
          creq_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next      = IDLE;
        creq_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      starve_cnt_reg  <= '0;
      creq_valid_reg  <= 1'b0;
      creq_write_reg  <= 1'b0;
      creq_addr_reg   <= '0;
      creq_size_reg   <= '0;
      creq_strobe_reg <= '0;
      creq_wdata_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      starve_cnt_reg  <= starve_cnt_next;
      creq_valid_reg  <= creq_valid_next;
      creq_write_reg  <= creq_write_next;
      creq_addr_reg   <= creq_addr_next;
      creq_size_reg   <= creq_size_next;
      creq_strobe_reg <= creq_strobe_next;
      creq_wdata_reg  <= creq_wdata_next;
    end
  end

  assign iresp_addr_ok = grant_i;
  assign dresp_addr_ok = grant_d;
  assign iresp_data    = cresp_data;
  assign dresp_data    = cresp_data;
  assign creq_valid    = creq_valid_reg;
  assign creq_write    = creq_write_reg;
  assign creq_addr     = creq_addr_reg;
  assign creq_size     = creq_size_reg;
  assign creq_strobe   = creq_strobe_reg;
  assign creq_wdata    = creq_wdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written
// starvation and mid-transaction reset sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [63:0] iresp_data;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid, creq_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_wdata;
  logic        cresp_ready;
  logic [63:0] cresp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_write(creq_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_wdata(creq_wdata),
    .cresp_ready(cresp_ready), .cresp_data(cresp_data)
  );

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv, dw;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dstb;
    logic [63:0] dwd;
    logic        rdy;
    logic [63:0] rdata;
    logic        e_iaok, e_daok, e_idok, e_ddok, e_cv;
    logic [63:0] e_caddr;
    logic        e_cw;
    logic [2:0]  e_csz;
    logic [7:0]  e_cstb;
    logic [63:0] e_cwd;
    logic [63:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [63:0] ia, input logic dv, input logic dw,
                     input logic [63:0] da, input logic [2:0] dsz, input logic [7:0] dstb,
                     input logic [63:0] dwd, input logic rdy, input logic [63:0] rdata,
                     input logic e_iaok, input logic e_daok, input logic e_idok, input logic e_ddok,
                     input logic e_cv, input logic [63:0] e_caddr, input logic e_cw,
                     input logic [2:0] e_csz, input logic [7:0] e_cstb, input logic [63:0] e_cwd,
                     input logic [63:0] e_data);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.dw = dw; v.da = da; v.dsz = dsz; v.dstb = dstb;
    v.dwd = dwd; v.rdy = rdy; v.rdata = rdata;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_cv = e_cv;
    v.e_caddr = e_caddr; v.e_cw = e_cw; v.e_csz = e_csz; v.e_cstb = e_cstb; v.e_cwd = e_cwd;
    v.e_data = e_data;
    vq.push_back(v);
  endtask

  task automatic set_in(input logic iv, input logic [63:0] ia, input logic dv, input logic dw,
                        input logic [63:0] da, input logic [2:0] dsz, input logic [7:0] dstb,
                        input logic [63:0] dwd, input logic rdy, input logic [63:0] rdata);
    ireq_valid = iv; ireq_addr = ia; dreq_valid = dv; dreq_write = dw; dreq_addr = da;
    dreq_size = dsz; dreq_strobe = dstb; dreq_wdata = dwd; cresp_ready = rdy; cresp_data = rdata;
  endtask

  // One line per completed transaction.
  task automatic log_txn();
    if (iresp_data_ok) $display("txn ibus addr=%h data=%h", creq_addr, iresp_data);
    if (dresp_data_ok) $display("txn dbus addr=%h write=%0b data=%h", creq_addr, creq_write, dresp_data);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: transaction-level view of the port.
  bit          m_busy;
  bit          m_own_i;
  int          m_run;
  logic [63:0] m_addr, m_wd;
  logic        m_w;
  logic [2:0]  m_sz;
  logic [7:0]  m_stb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_cv", creq_valid, 0);
    chk("reset_caddr", creq_addr, 0);
    chk("reset_cw", creq_write, 0);
    chk("reset_csz", creq_size, 0);
    chk("reset_cstb", creq_strobe, 0);
    chk("reset_cwd", creq_wdata, 0);
    rst = 1'b0;
    next_cycle();

    // ---------------- directed vector table ----------------
    // ibus read: grant at c0, request visible c1, response at c3
    add(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 64'h8000_0000, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 64'h8000_0000, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h13,               0, 0, 1, 0, 1, 64'h8000_0000, 0, 3, 0, 0, 64'h13);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // store held through 5 wait cycles while dbus inputs change
    add(0, 0, 1, 1, 64'h100, 3, 8'hFF, 64'hDEAD, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 64'h999, 1, 8'h01, 64'h1111, 0, 0, 0, 0, 0, 0, 1, 64'h100, 1, 3, 8'hFF, 64'hDEAD, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h42,               0, 0, 0, 1, 1, 64'h100, 1, 3, 8'hFF, 64'hDEAD, 64'h42);
    // spurious cresp_ready in IDLE
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h5,                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // both valid: dbus load first (strobe masked), ibus after
    add(1, 64'h200, 1, 0, 64'h300, 2, 8'hFF, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 64'h200, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 1, 64'h300, 0, 2, 0, 0, 0);
    add(1, 64'h200, 0, 0, 0, 0, 0, 0, 1, 64'h55,         0, 0, 0, 1, 1, 64'h300, 0, 2, 0, 0, 64'h55);
    add(1, 64'h200, 0, 0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 64'h200, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77,               0, 0, 1, 0, 1, 64'h200, 0, 3, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[k]) begin
      set_in(vq[k].iv, vq[k].ia, vq[k].dv, vq[k].dw, vq[k].da, vq[k].dsz, vq[k].dstb,
             vq[k].dwd, vq[k].rdy, vq[k].rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_iaok", k), iresp_addr_ok, vq[k].e_iaok);
      chk($sformatf("vec%0d_daok", k), dresp_addr_ok, vq[k].e_daok);
      chk($sformatf("vec%0d_idok", k), iresp_data_ok, vq[k].e_idok);
      chk($sformatf("vec%0d_ddok", k), dresp_data_ok, vq[k].e_ddok);
      chk($sformatf("vec%0d_cv", k), creq_valid, vq[k].e_cv);
      if (vq[k].e_cv) begin
        chk($sformatf("vec%0d_caddr", k), creq_addr, vq[k].e_caddr);
        chk($sformatf("vec%0d_cw", k), creq_write, vq[k].e_cw);
        chk($sformatf("vec%0d_csz", k), creq_size, vq[k].e_csz);
        chk($sformatf("vec%0d_cstb", k), creq_strobe, vq[k].e_cstb);
        if (vq[k].e_cw) chk($sformatf("vec%0d_cwd", k), creq_wdata, vq[k].e_cwd);
      end
      if (vq[k].e_idok) chk($sformatf("vec%0d_idata", k), iresp_data, vq[k].e_data);
      if (vq[k].e_ddok) chk($sformatf("vec%0d_ddata", k), dresp_data, vq[k].e_data);
      log_txn();
      next_cycle();
    end

    // ---------------- starvation: both held, memory always ready ----------------
    // Expected grant order: d d d d i d d d d i
    set_in(1, 64'h4000, 1, 0, 64'h5000, 3, 0, 0, 1, 64'hAB);
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      log_txn();
      if (iresp_addr_ok || dresp_addr_ok) begin
        chk($sformatf("starve_grant%0d_is_ibus", n), iresp_addr_ok, (n % 5 == 4));
        chk($sformatf("starve_grant%0d_single", n), iresp_addr_ok & dresp_addr_ok, 0);
        n++;
      end
      next_cycle();
    end
    chk("starve_grant_count", n, 10);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hAB);
    @(negedge clk);
    log_txn();
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    // ---------------- async reset while DBUSY ----------------
    set_in(0, 0, 1, 1, 64'h600, 3, 8'hF0, 64'h1234, 0, 0);
    @(negedge clk);
    chk("rst_seq_daok", dresp_addr_ok, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_seq_cv_before", creq_valid, 1);
    #2;
    rst = 1'b1;
    cresp_ready = 1'b1;
    #1;
    chk("rst_seq_cv_async", creq_valid, 0);
    chk("rst_seq_no_ddok", dresp_data_ok, 0);
    chk("rst_seq_no_idok", iresp_data_ok, 0);
    #1;
    rst = 1'b0;
    cresp_ready = 1'b0;
    next_cycle();
    set_in(1, 64'h700, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_iaok", iresp_addr_ok, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_cv", creq_valid, 1);
    chk("post_rst_caddr", creq_addr, 64'h700);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h99);
    @(negedge clk);
    chk("post_rst_idok", iresp_data_ok, 1);
    chk("post_rst_idata", iresp_data, 64'h99);
    log_txn();
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // ---------------- randomized traffic vs reference model ----------------
    m_busy = 0; m_own_i = 0; m_run = 0;
    m_addr = '0; m_wd = '0; m_w = 0; m_sz = '0; m_stb = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic e_gi, e_gd, was_idle;
      set_in($urandom_range(0, 1), {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
             $urandom_range(0, 1), {$urandom, $urandom}, 3'($urandom_range(0, 3)),
             8'($urandom), {$urandom, $urandom}, ($urandom_range(0, 9) < 4), {$urandom, $urandom});
      @(negedge clk);
      was_idle = !m_busy;
      e_gi = was_idle && ireq_valid && (!dreq_valid || m_run == 4);
      e_gd = was_idle && dreq_valid && !e_gi;
      chk($sformatf("rnd%0d_iaok", cyc), iresp_addr_ok, e_gi);
      chk($sformatf("rnd%0d_daok", cyc), dresp_addr_ok, e_gd);
      chk($sformatf("rnd%0d_cv", cyc), creq_valid, m_busy);
      chk($sformatf("rnd%0d_idok", cyc), iresp_data_ok, m_busy && m_own_i && cresp_ready);
      chk($sformatf("rnd%0d_ddok", cyc), dresp_data_ok, m_busy && !m_own_i && cresp_ready);
      if (m_busy) begin
        chk($sformatf("rnd%0d_caddr", cyc), creq_addr, m_addr);
        chk($sformatf("rnd%0d_cw", cyc), creq_write, m_w);
        chk($sformatf("rnd%0d_csz", cyc), creq_size, m_sz);
        chk($sformatf("rnd%0d_cstb", cyc), creq_strobe, m_stb);
        if (m_w) chk($sformatf("rnd%0d_cwd", cyc), creq_wdata, m_wd);
        if (cresp_ready && m_own_i) chk($sformatf("rnd%0d_idata", cyc), iresp_data, cresp_data);
        if (cresp_ready && !m_own_i) chk($sformatf("rnd%0d_ddata", cyc), dresp_data, cresp_data);
      end
      log_txn();
      if (e_gi) begin
        m_busy = 1; m_own_i = 1; m_addr = ireq_addr; m_w = 0; m_sz = 3; m_stb = 0; m_wd = 0;
        m_run = 0;
      end else if (e_gd) begin
        m_busy = 1; m_own_i = 0; m_addr = dreq_addr; m_w = dreq_write; m_sz = dreq_size;
        m_stb = dreq_write ? dreq_strobe : 8'h00; m_wd = dreq_wdata;
        if (ireq_valid && m_run < 4) m_run = m_run + 1;
      end else if (m_busy && cresp_ready) begin
        m_busy = 0;
      end
      if (was_idle && !ireq_valid) m_run = 0;
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
